usart_loopback: RTL
===================

Name: usart_loopback

Overview:
Parametrised single-clock USART loopback and echo block. It contains the following, all clocked by serial_clock:
- RX deserialiser
- synchronous FIFO
- TX serialiser
- RTS/CTS flow control and error counters

Unlike the previous echo block, it has configurable frame format (data bits, parity, stop bits), FIFO depth, hardware flow control on both sides, error accounting, and an enable gate. It is used as a link self-test and bring-up bridge on the comms board.

Parameters:
DATA_BITS, 8, bits per character (5..8), sent LSB first
PARITY, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, stop bits transmitted (1 or 2); receiver checks the first only
DEPTH, 16, FIFO entries; power of 2, >=4
RTS_MARGIN, 2, free entries remaining when rts_pin deasserts (1..DEPTH-1)

Ports:
serial_clock  input  1  sole clock, typically 3.6864MHz
reset  input  1  asynchronous, active-high
clocks_per_bit  input  12  serial_clock cycles per bit; values <4 treated as 4; sampled at each frame start
enable  input  1  1=block active
rx_pin  input  1  serial in, idle high, asynchronous
cts_pin  input  1  active-low clear-to-send from peer, asynchronous
tx_pin  output  1  serial out, idle high, registered
rts_pin  output  1  active-low request-to-send, registered
rx_led  output  1  high while RX is inside a frame
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy
frame_errors  output  8  saturating count of bad stop bits
parity_errors  output  8  saturating count of parity mismatches
overruns  output  8  saturating count of bytes dropped on full FIFO

Behaviour:
Reset values:
- tx_pin=1, rts_pin=0, rx_led=0
- fifo_count=0, all counters=0
- FSMs in IDLE
- FIFO pointers 0; contents undefined
- Reset mid-frame aborts both frames immediately; tx_pin returns high asynchronously.

Input synchronisation:
- rx_pin and cts_pin pass through 2-flop synchronisers before use.
- All timing below refers to the synchronised signals.

RX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE: a falling edge with enable=1 -> START; load divider with clocks_per_bit/2.
- START: at half-bit, sample the line. If high -> IDLE (glitch rejected, nothing counted). If low -> DATA; reload the divider with clocks_per_bit.
- DATA: sample DATA_BITS bits at full-bit intervals, shifting LSB first; then -> PARITY if PARITY!=0, else -> STOP.
- PARITY: compare the sampled bit against odd/even parity over the data. On mismatch, flag the character.
- STOP: sample one bit.
  - Low -> frame_errors++ and drop the character; RX waits for the line to go high before returning to IDLE.
  - High with parity flag set -> parity_errors++ and drop.
  - Otherwise push to the FIFO in the same cycle.
  - If both stop and parity errors occur, only frame_errors increments.
- rx_led = (state != IDLE).
- enable falling mid-frame -> RX returns to IDLE; nothing pushed, nothing counted.

FIFO:
- Push when full -> overruns++ and drop the byte, except when a pop occurs in the same cycle, in which case the push is accepted.
- Pop on empty is impossible.
- Order is strictly preserved.
- fifo_count updates the cycle after push/pop; a simultaneous push and pop leaves it unchanged.
- Pointer wrap uses an extra MSB; there is no lost entry at DEPTH.

Flow control:
- rts_pin = 1 when fifo_count >= DEPTH-RTS_MARGIN, else 0.
- rts_pin is registered, so it lags fifo_count by one cycle.
- RTS is advisory; incoming bytes are still accepted while space remains.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE: when FIFO non-empty, cts_pin=0 and enable=1, pop the byte, latch clocks_per_bit, -> START.
- The frame is: start bit (0), DATA_BITS bits LSB first, parity bit if enabled, then STOP_BITS high bits. Each bit lasts exactly the latched clocks_per_bit cycles.
- CTS and enable are checked only in IDLE. Deassertion mid-frame completes the current frame.
- Back-to-back frames: the next start bit follows the last stop bit with no idle gap.

Latency:
- RX push at cycle N; TX idle with CTS asserted.
- Pop at N+1; tx_pin low at N+2.

Counters:
- Each counter increments by 1 per event and saturates at 255.
- Counters are cleared only by reset.

Decomposition:
Shared package usart_pkg contains:
- parity encodings PARITY_NONE/ODD/EVEN
- the RX and TX state enums
- MIN_CLOCKS_PER_BIT=4

Sub-module sync_fifo (parameters WIDTH, DEPTH):
- valid/ready on both sides, plus a count output
- reusable by other single-clock comms blocks

The RX and TX FSMs stay inline in usart_loopback.

Test Plan:
1. 8N1, clocks_per_bit=16, cts_pin=0: receive 0x55 -> tx_pin emits start, bits 1,0,1,0,1,0,1,0, stop; first falling tx edge is 2 cycles after the push; all error counters remain 0.
2. PARITY=2 (even): receive 0x03 with parity bit 1 -> parity_errors=1, fifo_count stays 0, tx_pin stays high. Then 0x03 with parity bit 0 -> echoed with parity bit 0.
3. Stop bit driven low on a 0xA5 frame -> frame_errors=1, no push, rx_led held high until the line returns high.
4. DEPTH=16, RTS_MARGIN=2, cts_pin=1: send 17 bytes 0x00..0x10 -> rts_pin rises when fifo_count reaches 14; fifo_count=16, overruns=1. Then cts_pin=0 -> 0x00..0x0F transmitted in order, back-to-back.
5. rx_pin low pulse of clocks_per_bit/4 cycles -> RX returns to IDLE; no push, no counter change.
6. Assert reset mid-way through a TX data bit -> tx_pin=1 immediately. After release, fifo_count=0 and counters=0; a subsequent byte (0xC3) echoes correctly.

Source files
------------

// File: rtl/usart_pkg.sv
// Shared definitions for the USART loopback/echo block: parity encodings,
// RX/TX state encodings and small helpers used by the datapath.
package usart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Shortest bit period the dividers can handle (half-bit must be >= 2).
   localparam logic [11:0] MIN_CLOCKS_PER_BIT = 12'd4;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   // Parity bit to transmit / expect for a character (unused upper bits are zero).
   function automatic logic parity_bit(input logic [7:0] data, input int mode);
      return (mode == PARITY_ODD) ? ~(^data) : (^data);
   endfunction

   // 8-bit event counter increment that sticks at 255.
   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready on both sides and an occupancy output.
// Pointers carry an extra wrap bit so all DEPTH entries are usable.
module sync_fifo
   import usart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             full, empty, push, pop;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count     = wr_ptr_q - rd_ptr_q;
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   // A full FIFO still accepts a write when a read frees a slot in the same cycle.
   assign in_ready  = !full || pop;
   assign push      = in_valid && in_ready;
   assign out_data  = mem_q[rd_ptr_q[AW-1:0]];

   // Next-pointer computation.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // Pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write.
   // NOTE: the array has no reset; contents are only read once the pointers say they are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
   end

endmodule

// File: rtl/usart_loopback.sv
// USART loopback/echo: received characters are buffered in a FIFO and sent
// back out, with RTS/CTS flow control and saturating error counters.
module usart_loopback
   import usart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int DEPTH      = 16,
   parameter int RTS_MARGIN = 2
) (
   input  logic                     serial_clock,
   input  logic                     reset,
   input  logic [11:0]              clocks_per_bit,
   input  logic                     enable,
   input  logic                     rx_pin,
   input  logic                     cts_pin,
   output logic                     tx_pin,
   output logic                     rts_pin,
   output logic                     rx_led,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [7:0]               frame_errors,
   output logic [7:0]               parity_errors,
   output logic [7:0]               overruns
);

   localparam int            CW         = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] RTS_LEVEL  = CW'(DEPTH - RTS_MARGIN);
   localparam logic [2:0]    LAST_DATA  = 3'(DATA_BITS - 1);
   localparam logic [2:0]    LAST_STOP  = 3'(STOP_BITS - 1);
   localparam bit            HAS_PARITY = (PARITY != PARITY_NONE);

   // Synchronised inputs
   logic rx_meta_q, rx_sync_q, rx_prev_q, cts_meta_q, cts_sync_q;
   logic [11:0] cpb_eff;

   // RX datapath
   rx_state_t             rx_state_q, rx_state_d;
   logic [11:0]           rx_cnt_q, rx_cnt_d, rx_cpb_q, rx_cpb_d;
   logic [2:0]            rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
   logic                  rx_par_err_q, rx_par_err_d, rx_break_q, rx_break_d;
   logic                  rx_push, frame_evt, parity_evt, overrun_evt;

   // TX datapath
   tx_state_t             tx_state_q, tx_state_d;
   logic [11:0]           tx_cnt_q, tx_cnt_d, tx_cpb_q, tx_cpb_d;
   logic [2:0]            tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
   logic                  tx_par_q, tx_par_d, tx_pin_q, tx_pin_d;
   logic                  tx_load, tx_can_start;

   // FIFO and status
   logic                  fifo_in_ready, fifo_out_valid;
   logic [DATA_BITS-1:0]  fifo_out_data;
   logic                  rts_q, rts_d;
   logic [7:0]            frame_q, frame_d, parity_q, parity_d, overrun_q, overrun_d;

   assign cpb_eff      = (clocks_per_bit < MIN_CLOCKS_PER_BIT) ? MIN_CLOCKS_PER_BIT : clocks_per_bit;
   assign tx_can_start = fifo_out_valid && !cts_sync_q && enable;

   // Two-flop synchronisers on the asynchronous inputs, plus an edge-detect stage on rx.
   // NOTE: non-blocking assignments make each stage take the previous stage's pre-edge value; blocking would collapse the chain.
   always_ff @(posedge serial_clock or posedge reset) begin
      if (reset) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         cts_meta_q <= 1'b1;
         cts_sync_q <= 1'b1;
      end else begin
         rx_meta_q  <= rx_pin;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         cts_meta_q <= cts_pin;
         cts_sync_q <= cts_meta_q;
      end
   end

   // RX deserialiser: mid-bit sampling driven by a down-counting divider.
   // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_cpb_d     = rx_cpb_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_par_err_d = rx_par_err_q;
      rx_break_d   = rx_break_q;
      rx_push      = 1'b0;
      frame_evt    = 1'b0;
      parity_evt   = 1'b0;
      if (rx_state_q != RX_IDLE && !enable) begin
         rx_state_d = RX_IDLE;
      end else begin
         case (rx_state_q)
            RX_IDLE: begin
               if (enable && rx_prev_q && !rx_sync_q) begin
                  rx_state_d   = RX_START;
                  rx_cpb_d     = cpb_eff;
                  rx_cnt_d     = (cpb_eff >> 1) - 12'd1;
                  rx_par_err_d = 1'b0;
                  rx_break_d   = 1'b0;
               end
            end
            RX_START: begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_d = rx_cnt_q - 12'd1;
               end else if (rx_sync_q) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  rx_cnt_d   = rx_cpb_q - 12'd1;
                  rx_bit_d   = '0;
               end
            end
            RX_DATA: begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_d = rx_cnt_q - 12'd1;
               end else begin
                  rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                  rx_cnt_d   = rx_cpb_q - 12'd1;
                  rx_bit_d   = rx_bit_q + 3'd1;
                  if (rx_bit_q == LAST_DATA) rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
               end
            end
            RX_PARITY: begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_d = rx_cnt_q - 12'd1;
               end else begin
                  rx_par_err_d = (rx_sync_q != parity_bit(8'(rx_shift_q), PARITY));
                  rx_cnt_d     = rx_cpb_q - 12'd1;
                  rx_state_d   = RX_STOP;
               end
            end
            RX_STOP: begin
               if (rx_break_q) begin
                  // Bad stop bit seen: hold here until the line is idle again.
                  if (rx_sync_q) rx_state_d = RX_IDLE;
               end else if (rx_cnt_q != '0) begin
                  rx_cnt_d = rx_cnt_q - 12'd1;
               end else if (!rx_sync_q) begin
                  frame_evt  = 1'b1;
                  rx_break_d = 1'b1;
               end else if (rx_par_err_q) begin
                  parity_evt = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_push    = 1'b1;
                  rx_state_d = RX_IDLE;
               end
            end
            default: rx_state_d = RX_IDLE;
         endcase
      end
   end

   // TX serialiser: one latched bit period per bit, next frame loaded straight from the last stop bit.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_cpb_d   = tx_cpb_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_pin_d   = tx_pin_q;
      tx_load    = 1'b0;
      case (tx_state_q)
         TX_IDLE: tx_load = tx_can_start;
         TX_START: begin
            if (tx_cnt_q != '0) begin
               tx_cnt_d = tx_cnt_q - 12'd1;
            end else begin
               tx_state_d = TX_DATA;
               tx_pin_d   = tx_shift_q[0];
               tx_shift_d = tx_shift_q >> 1;
               tx_bit_d   = '0;
               tx_cnt_d   = tx_cpb_q - 12'd1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q != '0) begin
               tx_cnt_d = tx_cnt_q - 12'd1;
            end else begin
               tx_cnt_d = tx_cpb_q - 12'd1;
               if (tx_bit_q != LAST_DATA) begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_pin_d   = tx_shift_q[0];
                  tx_shift_d = tx_shift_q >> 1;
               end else if (HAS_PARITY) begin
                  tx_state_d = TX_PARITY;
                  tx_pin_d   = tx_par_q;
               end else begin
                  tx_state_d = TX_STOP;
                  tx_pin_d   = 1'b1;
                  tx_bit_d   = '0;
               end
            end
         end
         TX_PARITY: begin
            if (tx_cnt_q != '0) begin
               tx_cnt_d = tx_cnt_q - 12'd1;
            end else begin
               tx_state_d = TX_STOP;
               tx_pin_d   = 1'b1;
               tx_bit_d   = '0;
               tx_cnt_d   = tx_cpb_q - 12'd1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q != '0) begin
               tx_cnt_d = tx_cnt_q - 12'd1;
            end else if (tx_bit_q != LAST_STOP) begin
               tx_bit_d = tx_bit_q + 3'd1;
               tx_cnt_d = tx_cpb_q - 12'd1;
            end else begin
               tx_state_d = TX_IDLE;
               tx_load    = tx_can_start;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      if (tx_load) begin
         tx_state_d = TX_START;
         tx_pin_d   = 1'b0;
         tx_cpb_d   = cpb_eff;
         tx_cnt_d   = cpb_eff - 12'd1;
         tx_shift_d = fifo_out_data;
         tx_par_d   = parity_bit(8'(fifo_out_data), PARITY);
      end
   end

   // Error counters and RTS level.
   always_comb begin
      overrun_evt = rx_push && !fifo_in_ready;
      frame_d     = frame_evt   ? sat_inc(frame_q)   : frame_q;
      parity_d    = parity_evt  ? sat_inc(parity_q)  : parity_q;
      overrun_d   = overrun_evt ? sat_inc(overrun_q) : overrun_q;
      rts_d       = (fifo_count >= RTS_LEVEL);
   end

   // State registers for RX, TX, counters and RTS.
   always_ff @(posedge serial_clock or posedge reset) begin
      if (reset) begin
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_cpb_q     <= MIN_CLOCKS_PER_BIT;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_par_err_q <= 1'b0;
         rx_break_q   <= 1'b0;
         tx_state_q   <= TX_IDLE;
         tx_cnt_q     <= '0;
         tx_cpb_q     <= MIN_CLOCKS_PER_BIT;
         tx_bit_q     <= '0;
         tx_shift_q   <= '0;
         tx_par_q     <= 1'b0;
         tx_pin_q     <= 1'b1;
         rts_q        <= 1'b0;
         frame_q      <= '0;
         parity_q     <= '0;
         overrun_q    <= '0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_cpb_q     <= rx_cpb_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_par_err_q <= rx_par_err_d;
         rx_break_q   <= rx_break_d;
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_cpb_q     <= tx_cpb_d;
         tx_bit_q     <= tx_bit_d;
         tx_shift_q   <= tx_shift_d;
         tx_par_q     <= tx_par_d;
         tx_pin_q     <= tx_pin_d;
         rts_q        <= rts_d;
         frame_q      <= frame_d;
         parity_q     <= parity_d;
         overrun_q    <= overrun_d;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (serial_clock),
      .rst       (reset),
      .in_valid  (rx_push),
      .in_ready  (fifo_in_ready),
      .in_data   (rx_shift_q),
      .out_valid (fifo_out_valid),
      .out_ready (tx_load),
      .out_data  (fifo_out_data),
      .count     (fifo_count)
   );

   assign tx_pin        = tx_pin_q;
   assign rts_pin       = rts_q;
   assign rx_led        = (rx_state_q != RX_IDLE);
   assign frame_errors  = frame_q;
   assign parity_errors = parity_q;
   assign overruns      = overrun_q;

endmodule
